// File: rtl/pipeline_debug_pkg.sv
// Shared types and constants for the WB-stage commit trace transmitter.
// A frame is a sync byte, the destination register, then the data MSB first.
package pipeline_debug_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
   } commit_entry_t;

   function automatic logic [7:0] frame_byte(input commit_entry_t e, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = {3'b000, e.dest};
         3'd2:    b = e.data[31:24];
         3'd3:    b = e.data[23:16];
         3'd4:    b = e.data[15:8];
         3'd5:    b = e.data[7:0];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy count.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module commit_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Qualify requests against the registered flags and derive the next count.
   always_comb begin
      pop_ok_s    = pop && !empty_r;
      push_ok_s   = push && (!full_r || pop_ok_s);
      count_nxt_s = count_r;
      if (push_ok_s && !pop_ok_s) begin
         count_nxt_s = count_r + CW'(1'b1);
      end else if (!push_ok_s && pop_ok_s) begin
         count_nxt_s = count_r - CW'(1'b1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Storage array; no reset needed since reads are gated by empty.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, count and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CW'(DEPTH));
         empty_r <= (count_nxt_s == CW'(0));
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign full    = full_r;
   assign empty   = empty_r;
   assign count   = count_r;

endmodule

// File: rtl/pipeline_commit_tx.sv
// Traces register-file commits from the WB stage and sends each one as a
// 6-byte UART 8N1 frame; commits arriving while the buffer is full are dropped.
module pipeline_commit_tx
   import pipeline_debug_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWrite_WB,
   input  logic [4:0]  Write_register_WB,
   input  logic [31:0] Write_data_WB,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int ENTRY_W = $bits(commit_entry_t);
   localparam int BW      = $clog2(CLK_DIV);
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;

   tx_state_t     state_r;
   logic [BW-1:0] baud_r;
   logic [2:0]    bit_idx_r;
   logic [2:0]    byte_idx_r;
   commit_entry_t frame_r;
   logic          tx_r;
   logic          busy_r;
   logic          overflow_r;

   logic               push_req_s;
   logic               pop_s;
   logic               drop_s;
   logic               baud_wrap_s;
   logic [7:0]         cur_byte_s;
   commit_entry_t      push_entry_s;
   logic [ENTRY_W-1:0] fifo_rd_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [CW-1:0]      fifo_count_s;

   // Commit qualification, pop request and drop detection on the registered count.
   always_comb begin
      push_req_s   = RegWrite_WB && (Write_register_WB != 5'd0);
      push_entry_s = {Write_register_WB, Write_data_WB};
      pop_s        = (state_r == IDLE) && !fifo_empty_s;
      drop_s       = push_req_s && (fifo_count_s == CW'(FIFO_DEPTH)) && !pop_s;
      baud_wrap_s  = (baud_r == BW'(CLK_DIV - 1));
      cur_byte_s   = frame_byte(frame_r, byte_idx_r);
   end

   commit_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_req_s),
      .pop     (pop_s),
      .wr_data (push_entry_s),
      .rd_data (fifo_rd_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   // UART framing FSM; tx carries the level for the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         baud_r     <= '0;
         bit_idx_r  <= 3'd0;
         byte_idx_r <= 3'd0;
         frame_r    <= '0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  frame_r    <= commit_entry_t'(fifo_rd_s);
                  byte_idx_r <= 3'd0;
                  bit_idx_r  <= 3'd0;
                  baud_r     <= '0;
                  state_r    <= START;
                  tx_r       <= 1'b0;
                  busy_r     <= 1'b1;
               end else begin
                  tx_r   <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            START: begin
               if (baud_wrap_s) begin
                  baud_r    <= '0;
                  bit_idx_r <= 3'd0;
                  state_r   <= DATA;
                  tx_r      <= cur_byte_s[0];
               end else begin
                  baud_r <= baud_r + BW'(1'b1);
               end
            end
            DATA: begin
               if (baud_wrap_s) begin
                  baud_r <= '0;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= STOP;
                     tx_r    <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
                  end
               end else begin
                  baud_r <= baud_r + BW'(1'b1);
               end
            end
            STOP: begin
               if (baud_wrap_s) begin
                  baud_r <= '0;
                  if (byte_idx_r < 3'(FRAME_BYTES - 1)) begin
                     byte_idx_r <= byte_idx_r + 3'd1;
                     state_r    <= START;
                     tx_r       <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     tx_r    <= 1'b1;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  baud_r <= baud_r + BW'(1'b1);
               end
            end
            default: begin
               state_r <= IDLE;
               baud_r  <= '0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign tx        = tx_r;
   assign busy      = busy_r;
   assign fifo_full = fifo_full_s;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_pipeline_commit_tx.sv
// Directed bench for pipeline_commit_tx: frame contents and timing, $0 filter,
// full/overflow handling and asynchronous reset in the middle of a frame.
module tb_pipeline_commit_tx;

   localparam int CLK_DIV   = 4;
   localparam int DEPTH     = 8;
   localparam int FRAME_CYC = 60 * CLK_DIV;

   logic        clk;
   logic        rst_n;
   logic        RegWrite_WB;
   logic [4:0]  Write_register_WB;
   logic [31:0] Write_data_WB;
   logic        tx;
   logic        busy;
   logic        fifo_full;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_commit_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .RegWrite_WB       (RegWrite_WB),
      .Write_register_WB (Write_register_WB),
      .Write_data_WB     (Write_data_WB),
      .tx                (tx),
      .busy              (busy),
      .fifo_full         (fifo_full),
      .overflow          (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [4:0] r, input logic [31:0] d);
      RegWrite_WB       = 1'b1;
      Write_register_WB = r;
      Write_data_WB     = d;
      step();
      RegWrite_WB       = 1'b0;
   endtask

   function automatic logic [47:0] exp_frame(input logic [4:0] r, input logic [31:0] d);
      return {8'hA5, 3'b000, r, d};
   endfunction

   task automatic wait_start(input string tag, input int budget);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      check(tag, 64'(tx), 64'd0);
   endtask

   // Called on the first cycle tx is low; samples every bit at mid-point.
   task automatic rx_check(input string tag, input logic [47:0] exp);
      logic [47:0] frame;
      logic        fmt_ok;
      frame  = '0;
      fmt_ok = 1'b1;
      for (int c = 0; c < FRAME_CYC; c++) begin
         int b;
         int i;
         b = c / (10 * CLK_DIV);
         i = (c % (10 * CLK_DIV)) / CLK_DIV;
         if (c % CLK_DIV == CLK_DIV / 2) begin
            if (i == 0) begin
               if (tx !== 1'b0) fmt_ok = 1'b0;
            end else if (i == 9) begin
               if (tx !== 1'b1) fmt_ok = 1'b0;
            end else begin
               frame[40 - 8 * b + i - 1] = tx;
            end
         end
         step();
      end
      check(tag, 64'(frame), 64'(exp));
      check({tag, "_framing"}, 64'(fmt_ok), 64'd1);
      check({tag, "_end_busy"}, 64'(busy), 64'd0);
      check({tag, "_end_tx"}, 64'(tx), 64'd1);
   endtask

   task automatic quiet(input string tag, input int cycles);
      logic act;
      act = 1'b0;
      repeat (cycles) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0) act = 1'b1;
      end
      check(tag, 64'(act), 64'd0);
   endtask

   initial begin
      rst_n             = 1'b0;
      RegWrite_WB       = 1'b0;
      Write_register_WB = 5'd0;
      Write_data_WB     = 32'd0;
      step();
      step();
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_full", 64'(fifo_full), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      step();
      step();

      // Single commit: pop and start bit on the edge after the commit edge.
      commit(5'd8, 32'h12345678);
      check("pre_pop_tx", 64'(tx), 64'd1);
      step();
      check("start_tx", 64'(tx), 64'd0);
      check("start_busy", 64'(busy), 64'd1);
      rx_check("single", exp_frame(5'd8, 32'h12345678));

      // Writes to $0 never traced.
      commit(5'd0, 32'hFFFFFFFF);
      quiet("zero_reg_quiet", 20);

      // No RegWrite, arbitrary reg/data.
      begin
         logic act;
         act = 1'b0;
         for (int i = 0; i < 100; i++) begin
            Write_register_WB = 5'(i + 1);
            Write_data_WB     = 32'(i) * 32'h01234567;
            step();
            if (tx !== 1'b1 || busy !== 1'b0) act = 1'b1;
         end
         check("no_write_quiet", 64'(act), 64'd0);
      end

      // Fill during a frame, then push on the pop edge.
      commit(5'd20, 32'hC0DE0014);
      step();
      check("pp_start", 64'(tx), 64'd0);
      for (int r = 21; r <= 28; r++) commit(5'(r), 32'hC0DE0000 | 32'(r));
      check("pp_full", 64'(fifo_full), 64'd1);
      check("pp_ovf_before", 64'(overflow), 64'd0);
      repeat (FRAME_CYC - 8) step();
      check("pp_idle_busy", 64'(busy), 64'd0);
      commit(5'd29, 32'hC0DE001D);
      check("pp_full_after", 64'(fifo_full), 64'd1);
      check("pp_ovf_after", 64'(overflow), 64'd0);
      check("pp_next_start", 64'(tx), 64'd0);
      for (int r = 21; r <= 29; r++) begin
         if (r > 21) begin
            step();
            check("pp_gap", 64'(tx), 64'd0);
         end
         rx_check("pp_frame", exp_frame(5'(r), 32'hC0DE0000 | 32'(r)));
      end
      quiet("pp_drained", 20);
      check("pp_empty_full", 64'(fifo_full), 64'd0);

      // Burst of 10 commits into an empty FIFO.
      fork
         begin
            for (int r = 1; r <= 10; r++) begin
               commit(5'(r), 32'hA0B00000 | 32'(r));
               if (r == 9) begin
                  check("burst_full9", 64'(fifo_full), 64'd1);
                  check("burst_ovf9", 64'(overflow), 64'd0);
               end
               if (r == 10) begin
                  check("burst_ovf10", 64'(overflow), 64'd1);
                  check("burst_full10", 64'(fifo_full), 64'd1);
               end
            end
         end
         begin
            wait_start("burst_start", 10);
            for (int f = 1; f <= 9; f++) begin
               if (f > 1) begin
                  step();
                  check("burst_gap", 64'(tx), 64'd0);
               end
               rx_check("burst_frame", exp_frame(5'(f), 32'hA0B00000 | 32'(f)));
            end
         end
      join
      quiet("burst_no_tenth", 300);

      // Asynchronous reset in byte 3 DATA.
      commit(5'd3, 32'hDEADBEEF);
      step();
      repeat (130) step();
      check("mid_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 64'(tx), 64'd1);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_full", 64'(fifo_full), 64'd0);
      check("mid_rst_ovf", 64'(overflow), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      commit(5'd31, 32'h00000000);
      wait_start("post_rst_start", 5);
      rx_check("post_rst", exp_frame(5'd31, 32'h00000000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
